// File: rtl/mem_stage_lsu_pkg.sv
// rtl/mem_stage_lsu_pkg.sv - core LSU control encoding, byte-enable constants and op helpers
package mem_stage_lsu_pkg;

  typedef enum logic [3:0] {
    LSU_NOP, LB, LH, LW, LBU, LHU, SB, SH, SW
  } lsuCtrl_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_WAIT_GNT, ST_WAIT_RSP
  } lsu_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic lsu_is_load(lsuCtrl_e c);
    return c inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic logic lsu_is_store(lsuCtrl_e c);
    return c inside {SB, SH, SW};
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/half of a read word and sign/zero-extends it
module lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  lsuCtrl_e    lsu_ctrl_i,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    shifted     = rdata_i >> {lane_i, 3'b000};
    byte_w      = shifted[7:0];
    half_w      = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_data_o = rdata_i;
    case (lsu_ctrl_i)
      LB:      load_data_o = {{24{byte_w[7]}}, byte_w};
      LBU:     load_data_o = {24'b0, byte_w};
      LH:      load_data_o = {{16{half_w[15]}}, half_w};
      LHU:     load_data_o = {16'b0, half_w};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: req/gnt/rvalid bus master with stall, alignment and timeout
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  lsuCtrl_e    lsu_ctrl_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] load_data_o,
  output logic        lsu_stall_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0] load_data_q, load_data_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_err_q, bus_err_d;

  logic        op_valid, misaligned, aligned, is_load;
  logic        waiting, timeout_hit, rsp_done, req;
  logic [31:0] aligned_rdata;

  lsu_load_align u_load_align (
    .rdata_i    (dmem_rdata_i),
    .lane_i     (addr_i[1:0]),
    .lsu_ctrl_i (lsu_ctrl_i),
    .load_data_o(aligned_rdata)
  );

  always_comb begin
    misaligned = 1'b0;
    case (lsu_ctrl_i)
      LH, LHU, SH: misaligned = addr_i[0];
      LW, SW:      misaligned = |addr_i[1:0];
      default:     misaligned = 1'b0;
    endcase
  end

  assign op_valid    = lsu_ctrl_i != LSU_NOP;
  assign aligned     = !misaligned;
  assign is_load     = lsu_is_load(lsu_ctrl_i);
  assign waiting     = state_q != ST_IDLE;
  assign timeout_hit = waiting && (tmo_cnt_q == TMO_LAST);
  assign rsp_done    = (state_q == ST_WAIT_RSP) && dmem_rvalid_i;

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = waiting ? tmo_cnt_q + 16'd1 : 16'd0;
    req       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid && aligned) begin
          req     = 1'b1;
          state_d = dmem_gnt_i ? ST_WAIT_RSP : ST_WAIT_GNT;
        end
      end
      ST_WAIT_GNT: begin
        req = !timeout_hit;
        if (dmem_gnt_i) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (dmem_rvalid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Timeout abandons the transfer regardless of any late handshake this cycle.
    if (timeout_hit) begin
      state_d   = ST_IDLE;
      tmo_cnt_d = 16'd0;
    end
  end

  assign misaligned_d = (state_q == ST_IDLE) && op_valid && misaligned;
  assign bus_err_d    = timeout_hit;

  always_comb begin
    load_data_d = load_data_q;
    if (rsp_done && is_load)            load_data_d = aligned_rdata;
    else if (timeout_hit || misaligned_d) load_data_d = 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tmo_cnt_q    <= 16'd0;
      load_data_q  <= 32'd0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      load_data_q  <= load_data_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
    end
  end

  always_comb begin
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = 32'd0;
    case (lsu_ctrl_i)
      LB, LBU, SB: dmem_be_o = BE_BYTE << addr_i[1:0];
      LH, LHU, SH: dmem_be_o = addr_i[1] ? {BE_HALF[1:0], 2'b00} : BE_HALF;
      LW, SW:      dmem_be_o = BE_WORD;
      default:     dmem_be_o = 4'b0000;
    endcase
    case (lsu_ctrl_i)
      SB:      dmem_wdata_o = {4{store_data_i[7:0]}};
      SH:      dmem_wdata_o = {2{store_data_i[15:0]}};
      SW:      dmem_wdata_o = store_data_i;
      default: dmem_wdata_o = 32'd0;
    endcase
  end

  // Request and stall are forced low while reset is held so the pipeline never sees a stale op.
  assign dmem_req_o   = req && !rst;
  assign dmem_we_o    = lsu_is_store(lsu_ctrl_i);
  assign dmem_addr_o  = {addr_i[31:2], 2'b00};
  assign lsu_stall_o  = !rst && op_valid && aligned && !rsp_done && !timeout_hit;
  assign load_data_o  = (rsp_done && is_load) ? aligned_rdata : load_data_q;
  assign misaligned_o = misaligned_q;
  assign bus_err_o    = bus_err_q;

endmodule
